sd_fifo_wb_multi: RTL and testbench

SD_FIFO_WB_MULTI -- requirements
Module: sd_fifo_wb_multi

---
 rtl/sd_fifo_wb_multi.sv | 219 +++++++++++++++++++++
 tb/tb_sd_fifo_wb_multi.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_fifo_wb_multi.sv
// Multi-channel Wishbone FIFO bridge: per channel one TX FIFO (bus pushes,
// stream pops) and one RX FIFO (stream pushes, bus pops), plus control,
// a response-timeout timer on channel 0 and a level interrupt.

// Fall-through FIFO with occupancy count, flush and full/empty guards.
module sd_fifo_wb_multi_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   cnt_reg;
    logic          push_ok, pop_ok;

    assign empty   = (cnt_reg == '0);
    assign full    = (cnt_reg == (AW+1)'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr_reg];

    // Storage write; stale contents are harmless because pointers own validity.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok)
            mem[wr_ptr_reg] <= din;
    end

    // Pointer and count update; flush wins over any concurrent push/pop.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push_ok && !pop_ok)
                cnt_reg <= cnt_reg + 1'b1;
            else if (pop_ok && !push_ok)
                cnt_reg <= cnt_reg - 1'b1;
        end
    end
endmodule

module sd_fifo_wb_multi #(
    parameter int            DW      = 8,
    parameter int            DEPTH   = 16,
    parameter int            NCH     = 2,
    parameter int            TO_W    = 8,
    parameter logic [TO_W-1:0] TO_INIT = {TO_W{1'b1}}
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [3:0]        wb_adr_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic [DW-1:0]     wb_dat_o,
    input  logic [DW/8-1:0]   wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    output logic              irq_o,
    output logic [NCH*DW-1:0] tx_data_o,
    output logic [NCH-1:0]    tx_valid_o,
    input  logic [NCH-1:0]    tx_ready_i,
    input  logic [NCH*DW-1:0] rx_data_i,
    input  logic [NCH-1:0]    rx_valid_i,
    output logic [NCH-1:0]    rx_ready_o
);
    logic              acc, wr_acc, rd_acc;
    logic [NCH-1:0]    tx_full, tx_empty, rx_full, rx_empty;
    logic [NCH-1:0]    tx_push_sel, rx_pop_sel;
    logic [NCH*DW-1:0] rx_head;
    logic [DW-1:0]     rdata, status;
    logic              flush_reg, timer_en_reg, armed_reg;
    logic [3:0]        irq_en_reg, irq_stat_reg, irq_set, irq_clr;
    logic [TO_W-1:0]   timer_reg;
    logic              tx0_accept, rx0_rise, timeout, overflow, underflow;
    logic              unused_sel;

    // Byte selects carry no meaning: every access is full-width.
    assign unused_sel = ^wb_sel_i;

    // Side effects happen only on the edge where ack rises.
    assign acc    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr_acc = acc & wb_we_i;
    assign rd_acc = acc & ~wb_we_i;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign tx_push_sel[gi] = wr_acc & (wb_adr_i == 4'(2*gi));
            assign rx_pop_sel[gi]  = rd_acc & (wb_adr_i == 4'(2*gi+1));

            sd_fifo_wb_multi_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
                .wb_clk_i (wb_clk_i),
                .wb_rst_i (wb_rst_i),
                .flush    (flush_reg),
                .push     (tx_push_sel[gi]),
                .pop      (tx_ready_i[gi]),
                .din      (wb_dat_i),
                .dout     (tx_data_o[gi*DW +: DW]),
                .empty    (tx_empty[gi]),
                .full     (tx_full[gi])
            );

            sd_fifo_wb_multi_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
                .wb_clk_i (wb_clk_i),
                .wb_rst_i (wb_rst_i),
                .flush    (flush_reg),
                .push     (rx_valid_i[gi]),
                .pop      (rx_pop_sel[gi]),
                .din      (rx_data_i[gi*DW +: DW]),
                .dout     (rx_head[gi*DW +: DW]),
                .empty    (rx_empty[gi]),
                .full     (rx_full[gi])
            );

            assign tx_valid_o[gi] = ~tx_empty[gi];
            assign rx_ready_o[gi] = ~rx_full[gi];
        end
    endgenerate

    // Status word: TX full on even bits, RX empty on odd bits.
    always_comb begin
        status = '0;
        for (int i = 0; i < NCH; i++) begin
            status[2*i]   = tx_full[i];
            status[2*i+1] = rx_empty[i];
        end
    end

    // Read-data mux; anything unmapped reads as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCH; i++)
            if (wb_adr_i == 4'(2*i+1) && !rx_empty[i])
                rdata = rx_head[i*DW +: DW];
        case (wb_adr_i)
            4'h8:    rdata = status;
            4'h9:    rdata[1] = timer_en_reg;
            4'hA:    rdata = DW'(timer_reg);
            4'hB:    rdata[3:0] = irq_en_reg;
            4'hC:    rdata[3:0] = irq_stat_reg;
            default: ;
        endcase
    end

    // Interrupt events and write-1-to-clear mask; set beats clear.
    always_comb begin
        tx0_accept = tx_push_sel[0] & ~tx_full[0] & ~flush_reg;
        rx0_rise   = rx_valid_i[0] & rx_empty[0] & ~flush_reg;
        overflow   = |(tx_push_sel & tx_full);
        underflow  = |(rx_pop_sel & rx_empty);
        timeout    = armed_reg & ~tx0_accept & rx_empty[0] & timer_en_reg
                     & (timer_reg == TO_W'(1));
        irq_set    = {rx0_rise, underflow, overflow, timeout};
        irq_clr    = (wr_acc && wb_adr_i == 4'hC) ? wb_dat_i[3:0] : 4'h0;
    end

    // Bus handshake, control/interrupt registers and registered irq line.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o     <= 1'b0;
            wb_dat_o     <= '0;
            flush_reg    <= 1'b0;
            timer_en_reg <= 1'b0;
            irq_en_reg   <= 4'h0;
            irq_stat_reg <= 4'h0;
            irq_o        <= 1'b0;
        end else begin
            wb_ack_o     <= acc;
            wb_dat_o     <= rd_acc ? rdata : '0;
            flush_reg    <= wr_acc & (wb_adr_i == 4'h9) & wb_dat_i[0];
            if (wr_acc && wb_adr_i == 4'h9)
                timer_en_reg <= wb_dat_i[1];
            if (wr_acc && wb_adr_i == 4'hB)
                irq_en_reg <= wb_dat_i[3:0];
            irq_stat_reg <= (irq_stat_reg & ~irq_clr) | irq_set;
            irq_o        <= |(irq_stat_reg & irq_en_reg);
        end
    end

    // Response timer: reload on channel-0 push, count while RX0 stays empty.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            timer_reg <= TO_INIT;
            armed_reg <= 1'b0;
        end else if (tx0_accept) begin
            timer_reg <= TO_INIT;
            armed_reg <= 1'b1;
        end else if (armed_reg) begin
            if (!rx_empty[0]) begin
                armed_reg <= 1'b0;
            end else if (timer_en_reg) begin
                if (timer_reg != '0)
                    timer_reg <= timer_reg - 1'b1;
                if (timer_reg <= TO_W'(1))
                    armed_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sd_fifo_wb_multi.sv
// Scoreboard bench: bus tasks queue expected read data, a monitor pops and
// compares on every acknowledge; a stream monitor checks TX0 output order.
module tb_sd_fifo_wb_multi;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  adr = '0;
    logic [31:0] dat_w = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0, dsel = 1'b0;

    logic [7:0]  dat0;
    logic        ack0, irq0;
    logic [15:0] tx_data0, rx_data0;
    logic [1:0]  tx_valid0, rx_ready0, rx_valid0;
    logic [1:0]  tx_ready = 2'b00;
    logic        rx0_v = 1'b0, rx1_main_v = 1'b0, rx_valid_wrap = 1'b0;
    logic [7:0]  rx0_d = 8'h00, wrap_cur = 8'h00, wrap_data = 8'hA1;
    logic        wrap_on = 1'b0;

    logic [31:0] dat1, tx_data1;
    logic        ack1, irq1;
    logic [0:0]  tx_valid1, rx_ready1;

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          chk;
        bit          dut;
    } sb_t;
    sb_t         sbq[$];
    logic [7:0]  txq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ready_drops = 0;

    always #5 clk = ~clk;

    assign rx_valid0 = {rx_valid_wrap | rx1_main_v, rx0_v};
    assign rx_data0  = {(rx_valid_wrap ? wrap_cur : 8'hA0), rx0_d};

    sd_fifo_wb_multi #(.DW(8), .DEPTH(4), .NCH(2), .TO_W(8), .TO_INIT(8'd5)) u_dut0 (
        .wb_clk_i (clk),            .wb_rst_i (rst),
        .wb_adr_i (adr),            .wb_dat_i (dat_w[7:0]),
        .wb_dat_o (dat0),           .wb_sel_i (1'b1),
        .wb_we_i  (we),             .wb_cyc_i (cyc & ~dsel),
        .wb_stb_i (stb & ~dsel),    .wb_ack_o (ack0),
        .irq_o    (irq0),           .tx_data_o (tx_data0),
        .tx_valid_o (tx_valid0),    .tx_ready_i (tx_ready),
        .rx_data_i (rx_data0),      .rx_valid_i (rx_valid0),
        .rx_ready_o (rx_ready0)
    );

    sd_fifo_wb_multi #(.DW(32), .DEPTH(4), .NCH(1)) u_dut1 (
        .wb_clk_i (clk),            .wb_rst_i (rst),
        .wb_adr_i (adr),            .wb_dat_i (dat_w),
        .wb_dat_o (dat1),           .wb_sel_i (4'hF),
        .wb_we_i  (we),             .wb_cyc_i (cyc & dsel),
        .wb_stb_i (stb & dsel),     .wb_ack_o (ack1),
        .irq_o    (irq1),           .tx_data_o (tx_data1),
        .tx_valid_o (tx_valid1),    .tx_ready_i (1'b0),
        .rx_data_i (32'h0),         .rx_valid_i (1'b0),
        .rx_ready_o (rx_ready1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus access; the expected read value is queued before driving.
    task automatic bus(input bit d, input bit w, input logic [3:0] a,
                       input logic [31:0] wd, input string name, input logic [31:0] exp);
        sb_t e;
        int  n;
        e.name = name; e.exp = exp; e.chk = ~w; e.dut = d;
        sbq.push_back(e);
        @(negedge clk);
        dsel = d; adr = a; we = w; dat_w = wd; cyc = 1'b1; stb = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(ack0 | ack1) && n < 8);
        if (!(ack0 | ack1)) begin
            n_checks++; n_fail++;
            $display("FAIL %s_ack: no acknowledge within %0d cycles, required one", name, n);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] wd);
        bus(1'b0, 1'b1, a, wd, "write", 32'h0);
    endtask
    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
        bus(1'b0, 1'b0, a, 32'h0, name, exp);
    endtask

    // Scoreboard monitor: every acknowledge consumes one queued expectation.
    initial forever begin
        sb_t         e;
        logic [31:0] act;
        @(posedge clk); #1;
        if (ack0 | ack1) begin
            if (sbq.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_ack: ack seen, none required");
            end else begin
                e   = sbq.pop_front();
                act = e.dut ? dat1 : {24'h0, dat0};
                $display("txn %s dut%0d %s data=%h", e.name, e.dut, e.chk ? "rd" : "wr", act);
                if (e.chk) check(e.name, act, e.exp);
            end
        end
    end

    // Stream monitor: TX0 pops in order; RX1 must stay ready while wrapping.
    initial forever begin
        @(negedge clk); #2;
        if (tx_valid0[0] && tx_ready[0]) begin
            if (txq.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL tx0_extra: pop of %h, none required", tx_data0[7:0]);
            end else begin
                check("tx0_data", {24'h0, tx_data0[7:0]}, {24'h0, txq.pop_front()});
            end
        end
        if (wrap_on && !rx_ready0[1]) ready_drops++;
    end

    // RX1 producer: push exactly on the cycles where an RX1 pop is accepted.
    initial forever begin
        @(negedge clk); #1;
        if (wrap_on && stb && cyc && !dsel && !ack0 && !we && adr == 4'h3) begin
            rx_valid_wrap = 1'b1;
            wrap_cur      = wrap_data;
            wrap_data     = wrap_data + 8'h1;
        end else begin
            rx_valid_wrap = 1'b0;
        end
    end

    initial begin
        // Reset values, with a request pending that must not be acknowledged.
        cyc = 1'b1; stb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'h0, ack0}, 32'h0);
        check("rst_dat", {24'h0, dat0}, 32'h0);
        check("rst_irq", {31'h0, irq0}, 32'h0);
        check("rst_tx_valid", {30'h0, tx_valid0}, 32'h0);
        check("rst_rx_ready", {30'h0, rx_ready0}, 32'h3);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk); rst = 1'b0;

        rd(4'h8, 32'h0A, "status_rst");
        rd(4'h9, 32'h00, "control_rst");
        rd(4'hB, 32'h00, "irq_en_rst");
        rd(4'hC, 32'h00, "irq_stat_rst");
        rd(4'hA, 32'h05, "timer_rst");

        // Push test: fill TX0, overflow, then drain in order.
        wr(4'h0, 32'h11); wr(4'h0, 32'h22); wr(4'h0, 32'h33); wr(4'h0, 32'h44);
        rd(4'h8, 32'h0B, "status_tx0_full");
        wr(4'h0, 32'h55);
        rd(4'hC, 32'h02, "irq_overflow");
        txq.push_back(8'h11); txq.push_back(8'h22); txq.push_back(8'h33); txq.push_back(8'h44);
        @(negedge clk); tx_ready[0] = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        check("tx0_drained", {31'h0, tx_valid0[0]}, 32'h0);
        tx_ready[0] = 1'b0;
        wr(4'hC, 32'h2);
        rd(4'hC, 32'h00, "irq_clear_ovf");

        // Underflow with interrupt enabled.
        wr(4'hB, 32'h4);
        rd(4'h1, 32'h00, "rx0_underflow");
        check("irq_before", {31'h0, irq0}, 32'h0);
        @(posedge clk); #1;
        check("irq_rise", {31'h0, irq0}, 32'h1);
        wr(4'hC, 32'h4);
        check("irq_hold", {31'h0, irq0}, 32'h1);
        @(posedge clk); #1;
        check("irq_drop", {31'h0, irq0}, 32'h0);
        rd(4'hC, 32'h00, "irq_stat_cleared");
        rd(4'hB, 32'h04, "irq_en_rb");
        wr(4'hB, 32'h0);

        // Timeout: armed with timer stopped, then enable and count to zero.
        wr(4'h0, 32'h66);
        rd(4'hA, 32'h05, "timer_loaded");
        wr(4'h9, 32'h2);
        rd(4'hA, 32'h04, "timer_4");
        rd(4'hC, 32'h00, "no_timeout_yet");
        rd(4'hA, 32'h00, "timer_0");
        rd(4'hC, 32'h01, "timeout_set");
        rd(4'hA, 32'h00, "timer_saturate");
        rd(4'h9, 32'h02, "control_rb");
        wr(4'hC, 32'h1);

        // Second run: RX0 response arrives as the count reaches 3.
        wr(4'h0, 32'h77);
        @(posedge clk);
        @(negedge clk); rx0_v = 1'b1; rx0_d = 8'h99;
        @(negedge clk); rx0_v = 1'b0;
        rd(4'hA, 32'h03, "timer_stop_3");
        rd(4'hC, 32'h08, "rx0_rise");
        rd(4'h1, 32'h99, "rx0_pop");
        rd(4'hA, 32'h03, "timer_disarmed");
        wr(4'hC, 32'hF);
        wr(4'h9, 32'h0);

        // Wrap test through RX1 with simultaneous push and pop.
        @(negedge clk); rx1_main_v = 1'b1;
        @(negedge clk); rx1_main_v = 1'b0;
        wrap_on = 1'b1;
        for (int k = 0; k < 12; k++)
            rd(4'h3, 32'hA0 + k, "rx1_wrap");
        wrap_on = 1'b0;
        rd(4'h3, 32'hAC, "rx1_last");
        rd(4'h3, 32'h00, "rx1_underflow");
        check("rx1_ready_drops", ready_drops, 0);

        // Flush: TX FIFOs empty next cycle, IRQ_STAT and timer untouched.
        wr(4'h2, 32'hB1); wr(4'h2, 32'hB2);
        check("tx_valid_pre_flush", {30'h0, tx_valid0}, 32'h3);
        check("tx1_head", {24'h0, tx_data0[15:8]}, 32'hB1);
        wr(4'h9, 32'h1);
        @(posedge clk); #1;
        check("tx_valid_flushed", {30'h0, tx_valid0}, 32'h0);
        rd(4'hC, 32'h04, "irq_after_flush");
        rd(4'h9, 32'h00, "flush_reads_0");
        rd(4'hA, 32'h03, "timer_after_flush");

        // Reset in the middle of a pending TX1 write.
        @(negedge clk);
        dsel = 1'b0; adr = 4'h2; we = 1'b1; dat_w = 32'hC3; cyc = 1'b1; stb = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ack", {31'h0, ack0}, 32'h0);
        @(negedge clk); cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk); rst = 1'b0;
        check("abort_tx1_empty", {31'h0, tx_valid0[1]}, 32'h0);
        rd(4'hC, 32'h00, "irq_after_reset");
        rd(4'hA, 32'h05, "timer_after_reset");
        wr(4'h2, 32'hD4);
        check("tx1_after_reset", {24'h0, tx_data0[15:8]}, 32'hD4);
        check("tx_valid_after_reset", {30'h0, tx_valid0}, 32'h2);

        // Unmapped addresses and channels beyond NCH.
        rd(4'hD, 32'h00, "unmapped_rd");
        wr(4'hE, 32'hFF);
        wr(4'h4, 32'h5A);
        rd(4'h5, 32'h00, "ch2_rd");
        rd(4'h0, 32'h00, "tx_port_rd");
        rd(4'h8, 32'h0A, "status_after_unmapped");

        // Wide single-channel instance.
        bus(1'b1, 1'b0, 4'h8, 32'h0, "p_status", 32'h0000_0002);
        bus(1'b1, 1'b0, 4'h2, 32'h0, "p_ch1_rd", 32'h0);
        bus(1'b1, 1'b1, 4'h2, 32'h1234_5678, "p_ch1_wr", 32'h0);
        bus(1'b1, 1'b0, 4'hC, 32'h0, "p_irq_stat", 32'h0);
        bus(1'b1, 1'b1, 4'h0, 32'hDEAD_BEEF, "p_tx0_wr", 32'h0);
        check("p_tx0_data", tx_data1, 32'hDEAD_BEEF);
        bus(1'b1, 1'b0, 4'hA, 32'h0, "p_timer", 32'h0000_00FF);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        check("txq_empty", txq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
